// File: rtl/osd_pkg.sv
// Shared constants, FSM state type and font helper for the score overlay.
package osd_pkg;

    localparam int unsigned GLYPH_W = 5;
    localparam int unsigned GLYPH_H = 7;
    localparam int unsigned COL_W   = 10;
    localparam int unsigned LINE_W  = 9;

    // Per-line horizontal drawing state.
    typedef enum logic [2:0] {
        StIdle,
        StWaitX,
        StDigL,
        StGap,
        StDigR,
        StDone
    } osd_state_e;

    // Font row MSB is the leftmost pixel, so glyph column 0 maps to bit GLYPH_W-1.
    function automatic logic font_bit(input logic [GLYPH_W-1:0] bits, input logic [2:0] gcol);
        return bits[3'(GLYPH_W - 1) - gcol];
    endfunction

endpackage

// File: rtl/osd_digit_font.sv
// Combinational 5x7 digit font ROM; codes 10..15 render blank.
module osd_digit_font
    import osd_pkg::*;
(
    input  logic [3:0]         digit,
    input  logic [2:0]         row,
    output logic [GLYPH_W-1:0] bits
);

    logic [GLYPH_W*GLYPH_H-1:0] glyph;

    // Whole glyph for the digit, row 0 in the top five bits.
    always_comb begin
        glyph = '0;
        case (digit)
            4'd0: glyph = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
            4'd1: glyph = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
            4'd2: glyph = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
            4'd3: glyph = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
            4'd4: glyph = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
            4'd5: glyph = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
            4'd6: glyph = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
            4'd7: glyph = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
            4'd8: glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
            4'd9: glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
            default: glyph = '0;
        endcase
    end

    // Pick the requested row out of the glyph.
    always_comb begin
        bits = '0;
        case (row)
            3'd0: bits = glyph[34:30];
            3'd1: bits = glyph[29:25];
            3'd2: bits = glyph[24:20];
            3'd3: bits = glyph[19:15];
            3'd4: bits = glyph[14:10];
            3'd5: bits = glyph[9:5];
            3'd6: bits = glyph[4:0];
            default: bits = '0;
        endcase
    end

endmodule

// File: rtl/osd_score_overlay.sv
// Two-digit score overlay driven by the OSD pixel/line/frame strobes.
module osd_score_overlay
    import osd_pkg::*;
#(
    parameter int unsigned X_START = 20,
    parameter int unsigned Y_START = 8,
    parameter int unsigned SCALE   = 2,
    parameter int unsigned GAP     = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pix_tick,
    input  logic       line_tick,
    input  logic       frame_start,
    input  logic [3:0] score_l,
    input  logic [3:0] score_r,
    output logic       osd_pixel,
    output logic       osd_active
);

    localparam logic [COL_W-1:0]  COL_X    = COL_W'(X_START);
    localparam logic [COL_W-1:0]  COL_SAT  = 10'h3FE;
    localparam logic [LINE_W-1:0] LINE_Y   = LINE_W'(Y_START);
    localparam logic [LINE_W-1:0] LINE_SAT = 9'h1FE;
    localparam logic [1:0]        SUB_LAST = 2'(SCALE - 1);
    localparam logic [2:0]        ROW_LAST = 3'(GLYPH_H - 1);
    localparam logic [2:0]        COL_LAST = 3'(GLYPH_W - 1);
    localparam logic [7:0]        GAP_LAST = 8'((GAP != 0) ? GAP - 1 : 0);

    logic [LINE_W-1:0] line_q, line_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [2:0]        row_q, row_d;
    logic [1:0]        vsub_q, vsub_d;
    logic              in_rows_q, in_rows_d;
    // Set by frame_start; without it the line counter stays parked outside the frame.
    logic              fvalid_q, fvalid_d;
    logic [3:0]        shadow_l_q, shadow_r_q;

    osd_state_e        state_q;
    logic [1:0]        hsub_q;
    logic [2:0]        hcol_q;
    logic [7:0]        gcnt_q;
    logic              pix_q, act_q;
    logic [GLYPH_W-1:0] bits_l, bits_r;

    osd_digit_font u_font_l (
        .digit (shadow_l_q),
        .row   (row_q),
        .bits  (bits_l)
    );

    osd_digit_font u_font_r (
        .digit (shadow_r_q),
        .row   (row_q),
        .bits  (bits_r)
    );

    // Position counters and glyph-row tracking, strobe priority frame > line > pixel.
    always_comb begin
        line_d    = line_q;
        col_d     = col_q;
        row_d     = row_q;
        vsub_d    = vsub_q;
        in_rows_d = in_rows_q;
        fvalid_d  = fvalid_q;
        if (frame_start) begin
            line_d    = '1;
            in_rows_d = 1'b0;
            fvalid_d  = 1'b1;
        end else if (line_tick) begin
            col_d = '1;
            if (fvalid_q) begin
                if (line_q == '1) begin
                    line_d = '0;
                end else if (line_q != LINE_SAT) begin
                    line_d = line_q + 9'd1;
                end
                if (line_d == LINE_Y) begin
                    in_rows_d = 1'b1;
                    row_d     = '0;
                    vsub_d    = '0;
                end else if (in_rows_q) begin
                    if (vsub_q != SUB_LAST) begin
                        vsub_d = vsub_q + 2'd1;
                    end else begin
                        vsub_d = '0;
                        if (row_q == ROW_LAST) begin
                            in_rows_d = 1'b0;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end
                end
            end
        end else if (pix_tick) begin
            if (col_q == '1) begin
                col_d = '0;
            end else if (col_q != COL_SAT) begin
                col_d = col_q + 10'd1;
            end
        end
    end

    // Counter, row and score shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q     <= '1;
            col_q      <= '1;
            row_q      <= '0;
            vsub_q     <= '0;
            in_rows_q  <= 1'b0;
            fvalid_q   <= 1'b0;
            shadow_l_q <= '0;
            shadow_r_q <= '0;
        end else begin
            line_q    <= line_d;
            col_q     <= col_d;
            row_q     <= row_d;
            vsub_q    <= vsub_d;
            in_rows_q <= in_rows_d;
            fvalid_q  <= fvalid_d;
            if (frame_start) begin
                shadow_l_q <= score_l;
                shadow_r_q <= score_r;
            end
        end
    end

    // Horizontal FSM with registered outputs for the column of each accepted pix_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hsub_q  <= '0;
            hcol_q  <= '0;
            gcnt_q  <= '0;
            pix_q   <= 1'b0;
            act_q   <= 1'b0;
        end else if (frame_start) begin
            state_q <= StIdle;
            pix_q   <= 1'b0;
            act_q   <= 1'b0;
        end else if (line_tick) begin
            state_q <= in_rows_d ? StWaitX : StIdle;
            pix_q   <= 1'b0;
            act_q   <= 1'b0;
        end else if (pix_tick) begin
            unique case (state_q)
                StWaitX: begin
                    if (col_d == COL_X) begin
                        state_q <= StDigL;
                        hsub_q  <= '0;
                        hcol_q  <= '0;
                        pix_q   <= enable & font_bit(bits_l, 3'd0);
                        act_q   <= enable;
                    end else begin
                        pix_q <= 1'b0;
                        act_q <= 1'b0;
                    end
                end
                StDigL: begin
                    act_q <= enable;
                    if (hsub_q != SUB_LAST) begin
                        hsub_q <= hsub_q + 2'd1;
                        pix_q  <= enable & font_bit(bits_l, hcol_q);
                    end else if (hcol_q != COL_LAST) begin
                        hsub_q <= '0;
                        hcol_q <= hcol_q + 3'd1;
                        pix_q  <= enable & font_bit(bits_l, hcol_q + 3'd1);
                    end else if (GAP != 0) begin
                        state_q <= StGap;
                        gcnt_q  <= '0;
                        pix_q   <= 1'b0;
                    end else begin
                        state_q <= StDigR;
                        hsub_q  <= '0;
                        hcol_q  <= '0;
                        pix_q   <= enable & font_bit(bits_r, 3'd0);
                    end
                end
                StGap: begin
                    act_q <= enable;
                    if (gcnt_q != GAP_LAST) begin
                        gcnt_q <= gcnt_q + 8'd1;
                        pix_q  <= 1'b0;
                    end else begin
                        state_q <= StDigR;
                        hsub_q  <= '0;
                        hcol_q  <= '0;
                        pix_q   <= enable & font_bit(bits_r, 3'd0);
                    end
                end
                StDigR: begin
                    if (hsub_q != SUB_LAST) begin
                        hsub_q <= hsub_q + 2'd1;
                        pix_q  <= enable & font_bit(bits_r, hcol_q);
                        act_q  <= enable;
                    end else if (hcol_q != COL_LAST) begin
                        hsub_q <= '0;
                        hcol_q <= hcol_q + 3'd1;
                        pix_q  <= enable & font_bit(bits_r, hcol_q + 3'd1);
                        act_q  <= enable;
                    end else begin
                        state_q <= StDone;
                        pix_q   <= 1'b0;
                        act_q   <= 1'b0;
                    end
                end
                default: begin
                    pix_q <= 1'b0;
                    act_q <= 1'b0;
                end
            endcase
        end else if (!enable) begin
            pix_q <= 1'b0;
            act_q <= 1'b0;
        end
    end

    assign osd_pixel  = pix_q;
    assign osd_active = act_q;

endmodule
